// File: rtl/pulpemu_clk_gating_ctrl_if.sv
// Request/acknowledge bundle between the gated-domain side and the clock-gating controller.
// Latency: none, plain wires.
// Backpressure: none; the request is a level and the acknowledge reports clock state.
// Ports: clk_en_req_i / ch_busy_i / drain_cyc_i / test_mode_i driven by the master;
//        clk_en_ack_o / clk_on_o / clk_gated_o driven by the controller (slave).
interface pulpemu_clk_gating_ctrl_if #(
  parameter int NB_CH   = 4,
  parameter int DRAIN_W = 4
);
  logic [NB_CH-1:0]   clk_en_req_i;
  logic [NB_CH-1:0]   ch_busy_i;
  logic [DRAIN_W-1:0] drain_cyc_i;
  logic               test_mode_i;
  logic [NB_CH-1:0]   clk_en_ack_o;
  logic [NB_CH-1:0]   clk_on_o;
  logic [NB_CH-1:0]   clk_gated_o;

  modport master (
    output clk_en_req_i, ch_busy_i, drain_cyc_i, test_mode_i,
    input  clk_en_ack_o, clk_on_o, clk_gated_o
  );

  modport slave (
    input  clk_en_req_i, ch_busy_i, drain_cyc_i, test_mode_i,
    output clk_en_ack_o, clk_on_o, clk_gated_o
  );
endinterface

// File: rtl/pulpemu_clk_gating_ctrl.sv
// Multi-channel clock-gating controller: one gated clock per domain from pulp_clk.
// Latency: stop at edge drain_cyc_i+1 after req falls (busy low); wake ack at edge WAKE_CYC.
// Backpressure: ch_busy_i restarts the drain window; the clock stops only after a full idle window.
// Ports: pulp_clk source clock, pulp_soc_rst_n async active-low reset,
//        ctrl (slave modport) carries per-channel req/busy/ack/ce/gated clocks plus test mode.
module pulpemu_clk_gating_ctrl #(
  parameter int               NB_CH    = 4,
  parameter int               DRAIN_W  = 4,
  parameter int               WAKE_CYC = 2,
  parameter logic [NB_CH-1:0] RST_ON   = {NB_CH{1'b1}}
) (
  input  logic                     pulp_clk,
  input  logic                     pulp_soc_rst_n,
  pulpemu_clk_gating_ctrl_if.slave ctrl
);

  localparam int WAKE_W = $clog2(WAKE_CYC);
  localparam int CNT_W  = (DRAIN_W > WAKE_W) ? DRAIN_W : WAKE_W;

  localparam logic [1:0] ST_ON    = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OFF   = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  localparam logic [CNT_W-1:0] WAKE_INIT = CNT_W'(WAKE_CYC - 1);

  logic [NB_CH-1:0] ce_vec;
  logic [NB_CH-1:0] ack_vec;
  logic [NB_CH-1:0] gated_vec;

  for (genvar i = 0; i < NB_CH; i++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ack_q;
    logic             req, busy;

    assign req  = ctrl.clk_en_req_i[i];
    assign busy = ctrl.ch_busy_i[i];

    // Request has priority over busy, busy over the countdown, so an abort
    // always wins and a busy domain can never be stopped mid-window.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_ON: begin
          if (!req) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(ctrl.drain_cyc_i);
          end
        end
        ST_DRAIN: begin
          if (req) begin
            state_d = ST_ON;
          end else if (busy) begin
            cnt_d = CNT_W'(ctrl.drain_cyc_i);
          end else if (cnt_q == '0) begin
            state_d = ST_OFF;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (req) begin
            state_d = ST_WAKE;
            cnt_d   = WAKE_INIT;
          end
        end
        default: begin // ST_WAKE
          if (!req) begin
            state_d = ST_OFF;
          end else if (cnt_q == '0) begin
            state_d = ST_ON;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end

    // CE and ack are registered from the next state so they change on the
    // same edge as the FSM and never have a combinational path to the gate.
    always_ff @(posedge pulp_clk or negedge pulp_soc_rst_n) begin
      if (!pulp_soc_rst_n) begin
        state_q <= RST_ON[i] ? ST_ON : ST_OFF;
        cnt_q   <= '0;
        ce_q    <= RST_ON[i];
        ack_q   <= RST_ON[i];
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ce_q    <= (state_d != ST_OFF) | ctrl.test_mode_i;
        ack_q   <= (state_d == ST_ON) | (state_d == ST_DRAIN);
      end
    end

    assign ce_vec[i]  = ce_q;
    assign ack_vec[i] = ack_q;

`ifdef PULPEMU_FPGA
    BUFGCE u_bufgce (
      .I  (pulp_clk),
      .CE (ce_q),
      .O  (gated_vec[i])
    );
`else
    // Behavioural BUFGCE: CE is captured while the clock is low, so a CE
    // change right after a rising edge cannot shorten the high phase.
    logic ce_lat;
    always_latch begin
      if (!pulp_clk) ce_lat <= ce_q;
    end
    assign gated_vec[i] = pulp_clk & ce_lat;
`endif
  end

  assign ctrl.clk_on_o     = ce_vec;
  assign ctrl.clk_en_ack_o = ack_vec;
  assign ctrl.clk_gated_o  = gated_vec;

endmodule

// File: tb/tb_pulpemu_clk_gating_ctrl.sv
module tb_pulpemu_clk_gating_ctrl;

  logic pulp_clk = 1'b0;
  logic pulp_soc_rst_n = 1'b1;
  always #5 pulp_clk = ~pulp_clk;

  pulpemu_clk_gating_ctrl_if #(.NB_CH(4), .DRAIN_W(4)) ifc ();

  pulpemu_clk_gating_ctrl #(
    .NB_CH    (4),
    .DRAIN_W  (4),
    .WAKE_CYC (2),
    .RST_ON   (4'b0101)
  ) dut (
    .pulp_clk       (pulp_clk),
    .pulp_soc_rst_n (pulp_soc_rst_n),
    .ctrl           (ifc.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] gated;
  assign gated = ifc.clk_gated_o;
  int gc0 = 0, gc1 = 0, gc2 = 0, gc3 = 0;
  always @(posedge gated[0]) gc0++;
  always @(posedge gated[1]) gc1++;
  always @(posedge gated[2]) gc2++;
  always @(posedge gated[3]) gc3++;

  function automatic int gcount(input int ch);
    case (ch)
      0: return gc0;
      1: return gc1;
      2: return gc2;
      default: return gc3;
    endcase
  endfunction

  task automatic tick();
    @(posedge pulp_clk);
    #1;
  endtask

  task automatic test_reset();
    int s[4];
    ifc.clk_en_req_i = 4'b0101;
    ifc.ch_busy_i    = 4'b0000;
    ifc.drain_cyc_i  = 4'd3;
    ifc.test_mode_i  = 1'b0;
    #1 pulp_soc_rst_n = 1'b0;
    #1;
    n_vec++;
    if (ifc.clk_on_o !== 4'b0101) begin
      n_err++; $display("FAIL reset_clk_on: got %b expected %b", ifc.clk_on_o, 4'b0101);
    end
    n_vec++;
    if (ifc.clk_en_ack_o !== 4'b0101) begin
      n_err++; $display("FAIL reset_ack: got %b expected %b", ifc.clk_en_ack_o, 4'b0101);
    end
    tick(); tick();
    pulp_soc_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) s[c] = gcount(c);
    repeat (4) tick();
    for (int c = 0; c < 4; c++) begin
      int exp_n;
      exp_n = (c % 2 == 0) ? 4 : 0;
      n_vec++;
      if (gcount(c) - s[c] !== exp_n) begin
        n_err++; $display("FAIL reset_gated_edges ch%0d: got %0d expected %0d", c, gcount(c) - s[c], exp_n);
      end
    end
  endtask

  // ch1 wakes: CE at edge 0, gated edges 1 and 2, ack visible at edge 2
  task automatic test_wake();
    int s;
    logic [1:0] exp_on_ack [3];
    int exp_edges [3];
    exp_on_ack[0] = 2'b10; exp_on_ack[1] = 2'b10; exp_on_ack[2] = 2'b11;
    exp_edges[0]  = 0;     exp_edges[1]  = 1;     exp_edges[2]  = 2;
    ifc.clk_en_req_i[1] = 1'b1;
    s = gc1;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_vec++;
      if ({ifc.clk_on_o[1], ifc.clk_en_ack_o[1]} !== exp_on_ack[e]) begin
        n_err++; $display("FAIL wake_on_ack edge%0d: got %b expected %b", e, {ifc.clk_on_o[1], ifc.clk_en_ack_o[1]}, exp_on_ack[e]);
      end
      n_vec++;
      if (gc1 - s !== exp_edges[e]) begin
        n_err++; $display("FAIL wake_edges edge%0d: got %0d expected %0d", e, gc1 - s, exp_edges[e]);
      end
    end
  endtask

  // ch1 stops with drain 3 and no busy: OFF at edge 4, edges 0..4 delivered
  task automatic test_stop();
    int s;
    ifc.clk_en_req_i[1] = 1'b0;
    ifc.drain_cyc_i     = 4'd3;
    s = gc1;
    for (int e = 0; e <= 4; e++) begin
      logic exp_b;
      tick();
      exp_b = (e < 4);
      n_vec++;
      if ({ifc.clk_on_o[1], ifc.clk_en_ack_o[1]} !== {exp_b, exp_b}) begin
        n_err++; $display("FAIL stop_on_ack edge%0d: got %b expected %b", e, {ifc.clk_on_o[1], ifc.clk_en_ack_o[1]}, {exp_b, exp_b});
      end
    end
    repeat (3) tick();
    n_vec++;
    if (gc1 - s !== 5) begin
      n_err++; $display("FAIL stop_edges: got %0d expected %0d", gc1 - s, 5);
    end
  endtask

  // busy high at edges 1-2 restarts the window: OFF at edge 6
  task automatic test_busy();
    ifc.clk_en_req_i[1] = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (ifc.clk_en_ack_o[1] !== 1'b1) begin
      n_err++; $display("FAIL busy_prewake_ack: got %b expected %b", ifc.clk_en_ack_o[1], 1'b1);
    end
    ifc.clk_en_req_i[1] = 1'b0;
    ifc.drain_cyc_i     = 4'd3;
    tick();                       // edge 0
    ifc.ch_busy_i[1] = 1'b1;
    tick(); tick();               // edges 1, 2
    ifc.ch_busy_i[1] = 1'b0;
    for (int e = 3; e <= 6; e++) begin
      logic exp_b;
      tick();
      exp_b = (e < 6);
      n_vec++;
      if (ifc.clk_en_ack_o[1] !== exp_b) begin
        n_err++; $display("FAIL busy_ack edge%0d: got %b expected %b", e, ifc.clk_en_ack_o[1], exp_b);
      end
    end
    n_vec++;
    if (ifc.clk_on_o[1] !== 1'b0) begin
      n_err++; $display("FAIL busy_clk_on: got %b expected %b", ifc.clk_on_o[1], 1'b0);
    end
  endtask

  // ch0 drain aborted at edge 2: clock never stops, ack stays high
  task automatic test_abort_drain();
    int s;
    int bad;
    bad = 0;
    s = gc0;
    ifc.clk_en_req_i[0] = 1'b0;
    ifc.drain_cyc_i     = 4'd3;
    tick(); tick();               // edges 0, 1
    ifc.clk_en_req_i[0] = 1'b1;
    for (int e = 2; e <= 6; e++) begin
      tick();
      if ({ifc.clk_on_o[0], ifc.clk_en_ack_o[0]} !== 2'b11) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++; $display("FAIL abort_drain_ack: got %0d low samples expected %0d", bad, 0);
    end
    n_vec++;
    if (gc0 - s !== 7) begin
      n_err++; $display("FAIL abort_drain_edges: got %0d expected %0d", gc0 - s, 7);
    end
  endtask

  // ch1 wake aborted after edge 0: OFF at edge 1, ack never rises
  task automatic test_abort_wake();
    int s;
    s = gc1;
    ifc.clk_en_req_i[1] = 1'b1;
    tick();                       // edge 0 -> WAKE
    n_vec++;
    if ({ifc.clk_on_o[1], ifc.clk_en_ack_o[1]} !== 2'b10) begin
      n_err++; $display("FAIL abort_wake_e0: got %b expected %b", {ifc.clk_on_o[1], ifc.clk_en_ack_o[1]}, 2'b10);
    end
    ifc.clk_en_req_i[1] = 1'b0;
    tick();                       // edge 1 -> OFF
    n_vec++;
    if ({ifc.clk_on_o[1], ifc.clk_en_ack_o[1]} !== 2'b00) begin
      n_err++; $display("FAIL abort_wake_e1: got %b expected %b", {ifc.clk_on_o[1], ifc.clk_en_ack_o[1]}, 2'b00);
    end
    repeat (3) tick();
    n_vec++;
    if (ifc.clk_en_ack_o[1] !== 1'b0) begin
      n_err++; $display("FAIL abort_wake_ack_late: got %b expected %b", ifc.clk_en_ack_o[1], 1'b0);
    end
    n_vec++;
    if (gc1 - s !== 1) begin
      n_err++; $display("FAIL abort_wake_edges: got %0d expected %0d", gc1 - s, 1);
    end
  endtask

  // drain 0 stops at edge 1, then test mode forces all CE on without acks
  task automatic test_test_mode();
    ifc.clk_en_req_i = 4'b0000;
    ifc.drain_cyc_i  = 4'd0;
    tick();                       // edge 0 -> DRAIN
    n_vec++;
    if (ifc.clk_en_ack_o !== 4'b0101) begin
      n_err++; $display("FAIL drain0_e0_ack: got %b expected %b", ifc.clk_en_ack_o, 4'b0101);
    end
    tick();                       // edge 1 -> OFF
    n_vec++;
    if ({ifc.clk_on_o, ifc.clk_en_ack_o} !== 8'h00) begin
      n_err++; $display("FAIL drain0_e1: got %h expected %h", {ifc.clk_on_o, ifc.clk_en_ack_o}, 8'h00);
    end
    ifc.test_mode_i = 1'b1;
    tick();
    n_vec++;
    if ({ifc.clk_on_o, ifc.clk_en_ack_o} !== 8'hF0) begin
      n_err++; $display("FAIL test_mode_on: got %h expected %h", {ifc.clk_on_o, ifc.clk_en_ack_o}, 8'hF0);
    end
    tick();
    n_vec++;
    if (gated !== 4'b1111) begin
      n_err++; $display("FAIL test_mode_gated_high: got %b expected %b", gated, 4'b1111);
    end
    ifc.test_mode_i = 1'b0;
    tick();
    n_vec++;
    if ({ifc.clk_on_o, ifc.clk_en_ack_o} !== 8'h00) begin
      n_err++; $display("FAIL test_mode_release: got %h expected %h", {ifc.clk_on_o, ifc.clk_en_ack_o}, 8'h00);
    end
  endtask

  // async reset in the middle of a long drain window
  task automatic test_reset_mid_drain();
    ifc.clk_en_req_i = 4'b1111;
    repeat (3) tick();
    n_vec++;
    if (ifc.clk_en_ack_o !== 4'b1111) begin
      n_err++; $display("FAIL all_on_ack: got %b expected %b", ifc.clk_en_ack_o, 4'b1111);
    end
    ifc.clk_en_req_i = 4'b0000;
    ifc.drain_cyc_i  = 4'd15;
    repeat (3) tick();
    n_vec++;
    if (ifc.clk_en_ack_o !== 4'b1111) begin
      n_err++; $display("FAIL mid_drain_ack: got %b expected %b", ifc.clk_en_ack_o, 4'b1111);
    end
    #2 pulp_soc_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ifc.clk_on_o, ifc.clk_en_ack_o} !== 8'h55) begin
      n_err++; $display("FAIL async_reset: got %h expected %h", {ifc.clk_on_o, ifc.clk_en_ack_o}, 8'h55);
    end
    ifc.clk_en_req_i = 4'b0101;
    tick();
    pulp_soc_rst_n = 1'b1;
    repeat (20) tick();
    n_vec++;
    if ({ifc.clk_on_o, ifc.clk_en_ack_o} !== 8'h55) begin
      n_err++; $display("FAIL post_reset_hold: got %h expected %h", {ifc.clk_on_o, ifc.clk_en_ack_o}, 8'h55);
    end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_stop();
    test_busy();
    test_abort_drain();
    test_abort_wake();
    test_test_mode();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
